coin_frontend: RTL
==================

COIN_FRONTEND -- requirements
Module: coin_frontend

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive stable synchronized cycles required to accept a level change (legal range 1..255).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the coin-event queue depth (power of two, 2..16).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 coin_one_raw  input  1  asynchronous, bouncy one-dollar sensor, high = coin present.
REQ-006 coin_half_raw  input  1  asynchronous, bouncy half-dollar sensor, high = coin present.
REQ-007 accept_ready  input  1  high = downstream vending FSM can take a coin this cycle.
REQ-008 one_dollar  output  1  single-cycle registered pulse, one dollar credited downstream.
REQ-009 half_dollar  output  1  single-cycle registered pulse, half dollar credited downstream.
REQ-010 coin_reject  output  1  single-cycle pulse, a detected coin was dropped (return chute).
REQ-011 pending  output  $clog2(FIFO_DEPTH)+1  number of queued, not-yet-issued coins.
REQ-012 fifo_full  output  1  high when pending == FIFO_DEPTH.

Function
REQ-013 Each raw input SHALL pass through a two-flop synchronizer before any other logic.
REQ-014 Per channel, a debounce counter SHALL reset to 0 whenever the synchronized value equals the debounced level or changes, and the debounced level SHALL take the synchronized value on the edge where the counter reaches DEBOUNCE_CYCLES.
REQ-015 A coin event SHALL be a 0->1 transition of a channel's debounced level; 1->0 transitions SHALL generate nothing.
REQ-016 Events on both channels in the same cycle SHALL both be dropped with one coin_reject pulse the following cycle.
REQ-017 A single event SHALL be pushed on the next edge as one FIFO entry (1 = one dollar, 0 = half dollar).
REQ-018 An event arriving when fifo_full is high and no pop occurs that cycle SHALL be dropped with one coin_reject pulse the following cycle; push and pop in the same cycle when full SHALL both succeed.
REQ-019 Issue FSM states: IDLE, ISSUE, GAP.
REQ-020 IDLE -> ISSUE when pending != 0 and accept_ready == 1; on that edge the head entry SHALL be popped and one_dollar or half_dollar registered high accordingly.
REQ-021 ISSUE -> GAP unconditionally, clearing the pulse; GAP -> IDLE unconditionally, so issued pulses are separated by at least two low cycles.
REQ-022 accept_ready falling while in ISSUE or GAP SHALL NOT cancel or repeat the issued coin.
REQ-023 one_dollar and half_dollar SHALL never be high in the same cycle.
REQ-024 pending SHALL change by +1 on push-only, -1 on pop-only, 0 on push+pop; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Coins SHALL be issued in arrival order.

Reset
REQ-026 While reset is high: one_dollar = 0, half_dollar = 0, coin_reject = 0, pending = 0, fifo_full = 0, FSM = IDLE, debounced levels = 0, debounce counters = 0, synchronizer flops = 0.
REQ-027 Reset mid-operation SHALL discard all queued coins and any debounce in progress without emitting pulses; a raw input held high through reset release SHALL yield one event after 2 + DEBOUNCE_CYCLES cycles.

Configuration
REQ-028 With macro COIN_TALLY_EN defined, ports tally_clr (input, 1) and tally (output, 8, half-dollar units) SHALL exist; tally increments by 2 per one_dollar pulse and 1 per half_dollar pulse, saturates at 255, resets to 0, and tally_clr wins over a simultaneous increment.
REQ-029 Without COIN_TALLY_EN, tally_clr, tally and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 coin_one_raw 0->1 held 20 cycles, accept_ready = 1, DEBOUNCE_CYCLES = 4 -> exactly one one_dollar pulse, first high 2+4+3 cycles after the raw edge (±1 for sync), no half_dollar.
REQ-031 coin_half_raw toggling every cycle for 10 cycles, then 0 -> no event, no pulses, pending stays 0.
REQ-032 accept_ready = 0, five clean one-dollar coins, FIFO_DEPTH = 4 -> pending = 4, fifo_full = 1, one coin_reject pulse; then accept_ready = 1 -> four one_dollar pulses spaced 3 cycles apart, pending returns to 0.
REQ-033 Both raw inputs rise in the same cycle with identical bounce -> one coin_reject, no credit pulses.
REQ-034 Half, one, half queued with accept_ready = 0, reset asserted 1 cycle, then accept_ready = 1 -> no pulses, pending = 0.
REQ-035 COIN_TALLY_EN, 130 one-dollar coins issued -> tally = 255 (saturated); tally_clr pulse coincident with a pulse -> tally = 0.

Source files
------------

// File: rtl/coin_frontend.sv
// Coin acceptor front end: synchronize and debounce two coin sensors, queue coin events,
// and issue spaced credit pulses. Define COIN_TALLY_EN to add the saturating tally counter.
//
// state | meaning
// IDLE  | waiting for a queued coin and accept_ready
// ISSUE | credit pulse is high this cycle
// GAP   | enforced low cycle before the next coin can issue
module coin_frontend #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          coin_one_raw,
  input  logic                          coin_half_raw,
  input  logic                          accept_ready,
  output logic                          one_dollar,
  output logic                          half_dollar,
  output logic                          coin_reject,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          fifo_full
`ifdef COIN_TALLY_EN
  ,
  input  logic                          tally_clr,
  output logic [7:0]                    tally
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  // Channel index 1 is the one-dollar sensor, index 0 the half-dollar sensor.
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] deb;
  logic [1:0] rise;
  logic [7:0] cnt [2];

  assign raw = {coin_one_raw, coin_half_raw};

  // A single-bit input that differs from the debounced level can only "change" back to it,
  // so one equality test covers both counter-clear conditions.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      rise  <= '0;
      for (int ch = 0; ch < 2; ch++) cnt[ch] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int ch = 0; ch < 2; ch++) begin
        rise[ch] <= 1'b0;
        if (sync2[ch] == deb[ch]) begin
          cnt[ch] <= '0;
        end else if (cnt[ch] == DB_LAST) begin
          deb[ch]  <= sync2[ch];
          cnt[ch]  <= '0;
          rise[ch] <= sync2[ch];
        end else begin
          cnt[ch] <= cnt[ch] + 8'd1;
        end
      end
    end
  end

  logic          ev_both;
  logic          ev_single;
  logic          ev_is_one;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  state_t        state_nx;

  assign ev_both   = &rise;
  assign ev_single = ^rise;
  assign ev_is_one = rise[1];
  assign full      = (count == CW'(FIFO_DEPTH));
  assign pop       = (state == IDLE) && (count != '0) && accept_ready;
  assign push      = ev_single && (!full || pop);
  assign drop      = ev_both || (ev_single && full && !pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ev_is_one;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      coin_reject <= 1'b0;
      one_dollar  <= 1'b0;
      half_dollar <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      coin_reject <= drop;
      one_dollar  <= pop && mem[rd_ptr];
      half_dollar <= pop && !mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pop) state_nx = ISSUE;
      ISSUE:   state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign pending   = count;
  assign fifo_full = full;

`ifdef COIN_TALLY_EN
  // Tally is in half-dollar units and sticks at 255.
  always_ff @(posedge clk) begin
    if (reset || tally_clr) begin
      tally <= '0;
    end else if (one_dollar) begin
      tally <= (tally > 8'd253) ? 8'd255 : tally + 8'd2;
    end else if (half_dollar) begin
      tally <= (tally == 8'd255) ? 8'd255 : tally + 8'd1;
    end
  end
`endif

endmodule
